// File: rtl/uart_tx_serializer_if.sv
// uart_tx_serializer_if: show-ahead TX FIFO read port; master = serializer, slave = FIFO
interface uart_tx_serializer_if;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_read;
  modport master (input fifo_empty, fifo_data, output fifo_read);
  modport slave (output fifo_empty, fifo_data, input fifo_read);
endinterface

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: pops bytes from a show-ahead FIFO and sends 8N1/8P1/8N2 frames; ports clk, rst (async high), tx_enable, fifo (read port), tx, tx_busy, tx_done
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        tx_enable,
  uart_tx_serializer_if.master        fifo,
  output logic                        tx,
  output logic                        tx_busy,
  output logic                        tx_done
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic          stop_q, stop_d;
  logic [7:0]    sh_q, sh_d;
  logic          par_q, par_d, tx_q, tx_d, busy_q, busy_d, done_q, done_d;
  logic          last_bit, last_stop, pop;
  assign last_bit = cnt_q == CW'(CLKS_PER_BIT - 1);
  assign last_stop = state_q == STOP && last_bit && stop_q == 1'(STOP_BITS - 1);
  // Pops only from idle or in the very last stop cycle, giving zero-gap back-to-back frames
  assign pop = tx_enable & ~fifo.fifo_empty & (state_q == IDLE | last_stop);
  assign fifo.fifo_read = pop & ~rst;
  assign tx = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;
  always_comb begin
    state_d = state_q;
    cnt_d = (state_q == IDLE || last_bit) ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    stop_d = stop_q;
    sh_d = sh_q;
    par_d = par_q;
    tx_d = tx_q;
    case (state_q)
      START: if (last_bit) begin
        state_d = DATA;
        idx_d = 3'd0;
        tx_d = sh_q[0];
      end
      DATA: if (last_bit) begin
        if (idx_q == 3'd7) begin
          state_d = (PARITY_EN != 0) ? PARITY : STOP;
          tx_d = (PARITY_EN != 0) ? par_q : 1'b1;
          stop_d = 1'b0;
        end else begin
          idx_d = idx_q + 3'd1;
          tx_d = sh_q[idx_d];
        end
      end
      PARITY: if (last_bit) begin
        state_d = STOP;
        stop_d = 1'b0;
        tx_d = 1'b1;
      end
      STOP: if (last_bit) begin
        state_d = (stop_q == 1'(STOP_BITS - 1)) ? IDLE : STOP;
        stop_d = stop_q + 1'b1;
        tx_d = 1'b1;
      end
      default: ;
    endcase
    if (pop) begin
      state_d = START;
      cnt_d = '0;
      sh_d = fifo.fifo_data;
      par_d = ^fifo.fifo_data ^ PARITY_ODD[0];
      tx_d = 1'b0;
    end
    busy_d = state_d != IDLE;
    // Registered pulse: raised one cycle early so it lands in the final stop cycle
    done_d = state_q == STOP && cnt_q == CW'(CLKS_PER_BIT - 2) && stop_q == 1'(STOP_BITS - 1);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      stop_q <= 1'b0;
      sh_q <= '0;
      par_q <= 1'b0;
      tx_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      stop_q <= stop_d;
      sh_q <= sh_d;
      par_q <= par_d;
      tx_q <= tx_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
endmodule
